// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard deframer resolving E0/F0 prefixes into a held make code
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          byte_done_q, byte_done_d;
    logic [7:0]    byte_q, byte_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d;
    logic          key_valid_q, key_valid_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            // Lines idle high; starting the filter high avoids a spurious fall after reset.
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            wd_q        <= '0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            wd_q        <= wd_d;
            byte_done_q <= byte_done_d;
            byte_q      <= byte_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        fall_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        wd_d        = wd_q;
        byte_done_d = 1'b0;
        byte_d      = byte_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end

        if (fall_q) begin
            wd_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, data_sync_q};
                    state_d  = STOP;
                end
                default: begin
                    if (data_sync_q && par_ok_q) begin
                        byte_done_d = 1'b1;
                        byte_d      = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            wd_d = '0;
        end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
            wd_d        = '0;
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            wd_d = wd_q + WW'(1);
        end

        if (byte_done_q) begin
            if (byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else if (brk_pend_q) begin
                // A break only releases the key it names, including its E0 flavour.
                if (byte_q == key_code_q && ext_pend_q == key_ext_q) begin
                    key_code_d = '0;
                    key_ext_d  = 1'b0;
                end
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                key_code_d  = byte_q;
                key_ext_d   = ext_pend_q;
                key_valid_d = 1'b1;
                ext_pend_d  = 1'b0;
            end
        end

        if (frame_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule
